piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Transmit-side counterpart of the nibble deserializer.
- Accepts one parallel word over a valid/ready handshake and emits it as a stream of serial_size-bit beats, least-significant beat first.
- Emitting LSB beat first means a right-shifting SIPO at the far end reassembles the word with beat 0 at bits [serial_size-1:0].
- Sits at the NoC link egress, between the router output flit register and the narrow physical link.

Parameters:
- parallel_size, 32: width of the input word; must be an integer multiple of serial_size.
- serial_size, 4: width of one serial beat.
- BEATS (localparam), parallel_size/serial_size = 8: data beats per word.
- CNT_W (localparam), $clog2(BEATS) = 3: beat counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- in_data  input  parallel_size  word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- ser_data  output  serial_size  current serial beat.
- ser_valid  output  1  ser_data is valid.
- ser_ready  input  1  downstream accepts the beat this cycle.
- ser_last  output  1  marks the final beat of a word.

Behaviour:
- Reset:
  - reset is synchronous, active-high; clock is clk.
  - Next edge: state=IDLE, shift register=0, beat counter=0, parity register=0.
  - Outputs: ser_valid=0, ser_last=0, ser_data=0.
  - in_ready is forced 0 while reset is high and is 1 on the first cycle after reset drops.
- States: IDLE, SHIFT, plus PARITY when the optional feature is enabled.
- IDLE:
  - in_ready=1, ser_valid=0, ser_data=0.
  - in_valid=1: load in_data into the shift register, counter=0, go to SHIFT.
- SHIFT:
  - ser_valid=1; ser_data = shift_reg[serial_size-1:0].
  - Beat transfer is ser_valid && ser_ready: shift register shifts right by serial_size with zero fill, counter increments.
  - ser_last=1 when counter==BEATS-1 (feature off).
- Latency: first beat is visible the cycle after the input handshake. A word occupies at least BEATS cycles on the link.
- Backpressure: while ser_valid && !ser_ready, ser_data, ser_last, counter and shift register hold stable.
- Back-to-back:
  - in_ready = (state==IDLE) || (final beat present && ser_ready).
  - This is a combinational ser_ready->in_ready path; it is documented and accepted.
  - A load coinciding with the final beat transfer takes priority over returning to IDLE: no bubble between words, counter restarts at 0.
- End of word: final beat transferred and no new load -> IDLE, shift register cleared to 0.
- in_valid while in_ready=0 is ignored; in_data is not sampled.
- Reset mid-word: the word is discarded, no further beats are emitted, ser_valid=0 on the next cycle.
- Arithmetic: counter wraps only through an explicit reload to 0. It never exceeds BEATS-1.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- When defined:
  - On load, the parity register captures the XOR of all BEATS beats of in_data.
  - After beat BEATS-1 transfers, go to PARITY and present one extra beat: ser_data=parity, ser_valid=1, ser_last=1.
  - ser_last is 0 on data beats.
  - Back-to-back loading happens on the parity beat instead of the last data beat.
  - Word cost is BEATS+1 beats.
- When undefined: no PARITY state and no parity register; ser_last is on data beat BEATS-1.

Decomposition:
- Shared package serdes_pkg holds:
  - default SERIAL_SIZE/PARALLEL_SIZE constants
  - the BEATS derivation
  - the state enum typedef (IDLE, SHIFT, PARITY)
  - a beat-XOR function reused by the receive-side checker.
- No sub-module is natural; the datapath is one shift register plus a counter in a single module.

Test Plan:
- Single word: in_data=0x87654321, ser_ready=1 -> beats 1,2,3,4,5,6,7,8 on 8 consecutive cycles starting the cycle after the handshake; ser_last only on beat 8; then ser_valid=0, ser_data=0.
- Back-to-back: 0x87654321 then 0xFEDCBA98 with in_valid held -> 16 contiguous beats 1..8, 8..F with no idle cycle; second word accepted on the cycle beat 8 transfers.
- Backpressure: ser_ready=0 for 2 cycles while beat 3 is presented -> ser_data=3 held for 3 cycles, then 4..8 follow; total 10 cycles.
- Reset mid-word: assert reset after beat 3 transfers -> ser_valid=0, ser_data=0 next cycle; in_ready=1 the cycle after reset drops; the next word 0x11111111 emits eight 1 beats.
- Input ignored when busy: in_valid pulsed with 0xDEADBEEF during beat 4 of a word -> not accepted, stream unchanged.
- Parity (SERIALIZER_PARITY_EN): 0x87654321 -> 8 data beats, then a 9th beat 0x8 with ser_last=1; 0xFFFFFFFF -> parity beat 0x0.

Source files
------------

// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
//
// Shared definitions for the NoC link serializer / deserializer pair.
//
// Contents:
//   SERIAL_SIZE, PARALLEL_SIZE : default beat width and word width
//   BEATS, CNT_W               : beats per word and beat counter width
//   serdes_state_t             : transmit FSM states (IDLE, SHIFT, PARITY)
//   beat_xor()                 : XOR of all beats of a default-size word;
//                                used for the parity beat and by the
//                                receive-side checker
//
// Optional feature macro used by the users of this package:
//   SERIALIZER_PARITY_EN
// -----------------------------------------------------------------------------
package serdes_pkg;

    localparam int SERIAL_SIZE   = 4;
    localparam int PARALLEL_SIZE = 32;
    localparam int BEATS         = PARALLEL_SIZE / SERIAL_SIZE;
    localparam int CNT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;

    // PARITY is only reachable when SERIALIZER_PARITY_EN is defined.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } serdes_state_t;

    // Bitwise XOR of every SERIAL_SIZE-bit beat of a PARALLEL_SIZE-bit word.
    function automatic logic [SERIAL_SIZE-1:0] beat_xor(
        input logic [PARALLEL_SIZE-1:0] word
    );
        logic [SERIAL_SIZE-1:0] acc;
        acc = '0;
        for (int i = 0; i < BEATS; i++) begin
            acc = acc ^ word[i*SERIAL_SIZE +: SERIAL_SIZE];
        end
        return acc;
    endfunction

endpackage

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out serializer for the NoC link egress. Takes one
// parallel_size-bit word over a valid/ready handshake and emits it as
// parallel_size/serial_size beats, least-significant beat first, so that a
// right-shifting SIPO on the far side rebuilds the word with beat 0 in the
// low bits.
//
// Parameters:
//   parallel_size : input word width (integer multiple of serial_size)
//   serial_size   : serial beat width
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   in_data    in   [parallel_size-1:0] word to serialize
//   in_valid   in   in_data is valid
//   in_ready   out  a word can be accepted this cycle
//   ser_data   out  [serial_size-1:0] current serial beat
//   ser_valid  out  ser_data is valid
//   ser_ready  in   downstream accepts the beat this cycle
//   ser_last   out  final beat of a word
//
// Handshake semantics (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid keeps its data
// stable until the transfer; while ser_valid && !ser_ready the serial
// outputs and all internal state are held. in_ready depends combinationally
// on ser_ready (back-to-back reload on the final beat); this path is
// intentional.
//
// Optional feature (macro SERIALIZER_PARITY_EN): after the data beats one
// extra beat carrying the XOR of all data beats is sent, and ser_last moves
// from the last data beat to that parity beat.
// -----------------------------------------------------------------------------
module piso_serializer
    import serdes_pkg::*;
#(
    parameter int parallel_size = 32,
    parameter int serial_size   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [parallel_size-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [serial_size-1:0]   ser_data,
    output logic                     ser_valid,
    input  logic                     ser_ready,
    output logic                     ser_last
);

    localparam int BEATS_L = parallel_size / serial_size;
    localparam int CNT_W_L = (BEATS_L > 1) ? $clog2(BEATS_L) : 1;
    localparam logic [CNT_W_L-1:0] LAST_CNT = CNT_W_L'(BEATS_L - 1);

    serdes_state_t            state;
    logic [parallel_size-1:0] shift_reg;
    logic [CNT_W_L-1:0]       cnt;

    // Final beat of the word is currently on the link.
    logic final_beat;
    // The last data beat is on the link (differs from final_beat only when
    // a parity beat follows).
    logic last_data_beat;
    logic beat_xfer;
    logic load;

    assign last_data_beat = (state == SHIFT) && (cnt == LAST_CNT);
    assign beat_xfer      = ser_valid && ser_ready;

`ifdef SERIALIZER_PARITY_EN
    logic [serial_size-1:0] parity_reg;
    logic [serial_size-1:0] in_parity;

    // XOR of all beats of the incoming word, captured at load time.
    always_comb begin
        in_parity = '0;
        for (int i = 0; i < BEATS_L; i++) begin
            in_parity = in_parity ^ in_data[i*serial_size +: serial_size];
        end
    end

    assign final_beat = (state == PARITY);
    assign ser_valid  = (state == SHIFT) || (state == PARITY);
    assign ser_last   = (state == PARITY);
    assign ser_data   = (state == PARITY) ? parity_reg
                      : (state == SHIFT)  ? shift_reg[serial_size-1:0]
                      : '0;
`else
    assign final_beat = last_data_beat;
    assign ser_valid  = (state == SHIFT);
    assign ser_last   = last_data_beat;
    assign ser_data   = (state == SHIFT) ? shift_reg[serial_size-1:0] : '0;
`endif

    // A new word is taken either from IDLE or on the very cycle the final
    // beat leaves, which keeps consecutive words gap-free on the link.
    assign in_ready = !reset && ((state == IDLE) || (final_beat && ser_ready));
    assign load     = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            cnt       <= '0;
`ifdef SERIALIZER_PARITY_EN
            parity_reg <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state     <= SHIFT;
                        shift_reg <= in_data;
                        cnt       <= '0;
`ifdef SERIALIZER_PARITY_EN
                        parity_reg <= in_parity;
`endif
                    end
                end

                SHIFT: begin
                    if (beat_xfer) begin
                        if (last_data_beat) begin
`ifdef SERIALIZER_PARITY_EN
                            // Data exhausted; the parity beat follows.
                            state     <= PARITY;
                            shift_reg <= '0;
                            cnt       <= '0;
`else
                            // Reload takes priority over going idle.
                            if (load) begin
                                state     <= SHIFT;
                                shift_reg <= in_data;
                                cnt       <= '0;
                            end else begin
                                state     <= IDLE;
                                shift_reg <= '0;
                                cnt       <= '0;
                            end
`endif
                        end else begin
                            shift_reg <= shift_reg >> serial_size;
                            cnt       <= cnt + CNT_W_L'(1);
                        end
                    end
                end

`ifdef SERIALIZER_PARITY_EN
                PARITY: begin
                    if (beat_xfer) begin
                        if (load) begin
                            state      <= SHIFT;
                            shift_reg  <= in_data;
                            cnt        <= '0;
                            parity_reg <= in_parity;
                        end else begin
                            state      <= IDLE;
                            shift_reg  <= '0;
                            cnt        <= '0;
                            parity_reg <= '0;
                        end
                    end
                end
`endif

                default: begin
                    state     <= IDLE;
                    shift_reg <= '0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule
